// File: rtl/sock_pkg.sv
// Shared definitions for the sock factory line counters.
//   - material codes accepted on item_type
//   - size codes accepted on item_size
//   - pack codes driven towards the packer
//   - line FSM state encoding
package sock_pkg;

    // Material codes (item_type)
    localparam logic [2:0] ALGODON = 3'b001;
    localparam logic [2:0] LANA    = 3'b010;
    localparam logic [2:0] NYLON   = 3'b100;

    // Size codes (item_size)
    localparam logic [1:0] BAJOS   = 2'b01;
    localparam logic [1:0] MEDIOS  = 2'b10;
    localparam logic [1:0] ALTOS   = 2'b11;

    // Pack codes (pack_code)
    localparam logic [2:0] PACK_NONE          = 3'b000;
    localparam logic [2:0] PACK_ALGODON_BAJOS = 3'b001;
    localparam logic [2:0] PACK_LANA_BAJOS    = 3'b010;
    localparam logic [2:0] PACK_NYLON_BAJOS   = 3'b011;

    // Line FSM state encoding
    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_FULL  = 1'b1
    } line_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with sticky overflow flag.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset (q=0, ovf=0)
//   clr    in   synchronous clear, overrides en
//   en     in   count one event this cycle
//   q      out  W-bit count, saturates at all-ones
//   ovf    out  sticky: an event arrived while q was already all-ones
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         ovf
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            if (&q) begin
                ovf <= 1'b1;
            end else begin
                q <= q + W'(1);
            end
        end
    end

endmodule

// File: rtl/sock_pack_counter.sv
// Per-line sock counter: counts qualifying socks, requests a pack from the
// packer with a valid/ready handshake every PACK_SIZE socks, and keeps a
// saturating count of delivered packs.
// Ports:
//   clk, reset           clock / asynchronous active-high reset
//   ph, sr               machine enabled, sensor ready
//   item_valid/type/size presented sock
//   mode                 0: non-qualifying cycle clears partial count, 1: hold
//   clr                  synchronous clear of all state
//   item_ready           line accepts socks (COUNT state)
//   pack_valid/ready     handshake with the packer
//   pack_code            PACK_CODE while pack_valid, else 0
//   led                  current sock count
//   co                   pack accepted this cycle
//   pack_total(_ovf)     delivered packs (saturating) and sticky overflow
module sock_pack_counter
    import sock_pkg::*;
#(
    parameter int               CNT_W     = 3,
    parameter int               PACK_SIZE = 7,
    parameter int               TYPE_W    = 3,
    parameter int               SIZE_W    = 2,
    parameter logic [TYPE_W-1:0] TYPE_CODE = ALGODON,
    parameter logic [SIZE_W-1:0] SIZE_CODE = BAJOS,
    parameter logic [2:0]        PACK_CODE = PACK_ALGODON_BAJOS,
    parameter int               PACKS_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ph,
    input  logic               sr,
    input  logic               item_valid,
    input  logic [TYPE_W-1:0]  item_type,
    input  logic [SIZE_W-1:0]  item_size,
    input  logic               mode,
    input  logic               clr,
    output logic               item_ready,
    output logic               pack_valid,
    input  logic               pack_ready,
    output logic [2:0]         pack_code,
    output logic [CNT_W-1:0]   led,
    output logic               co,
    output logic [PACKS_W-1:0] pack_total,
    output logic               pack_total_ovf
);

    generate
        if (PACK_SIZE < 2 || PACK_SIZE > (2**CNT_W) - 1) begin : g_bad_pack_size
            $error("sock_pack_counter: PACK_SIZE out of range 2 .. 2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK_SIZE - 1);

    line_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             qual;

    assign item_ready = (state == ST_COUNT);
    assign pack_valid = (state == ST_FULL);
    assign pack_code  = pack_valid ? PACK_CODE : PACK_NONE;
    assign led        = cnt;

    // A clear on the same edge drops the pending pack, so it is not accepted.
    assign co = pack_valid & pack_ready & ~clr;

    assign qual = ph & sr & item_valid & (item_type == TYPE_CODE) &
                  (item_size == SIZE_CODE) & item_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_COUNT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (clr) begin
            state_n = ST_COUNT;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_COUNT: begin
                    if (qual) begin
                        if (cnt == CNT_LAST) begin
                            cnt_n   = CNT_FULL;
                            state_n = ST_FULL;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end else if (!mode) begin
                        cnt_n = '0;
                    end
                end
                ST_FULL: begin
                    if (pack_ready) begin
                        cnt_n   = '0;
                        state_n = ST_COUNT;
                    end
                end
                default: begin
                    state_n = ST_COUNT;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(PACKS_W)
    ) u_pack_total (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (co),
        .q     (pack_total),
        .ovf   (pack_total_ovf)
    );

endmodule
